mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequences load/store operations issued by the MEM pipeline stage onto a multi-cycle data-memory bus with a req/ack handshake.
- Stalls the pipeline while an access is outstanding.
- Extracts and extends sub-word load data (big-endian).
- Flags misaligned addresses and bus timeouts.
- Sits beside the MEM stage; its load result feeds that stage's write-back data mux.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for bus_ack before aborting.
- TIMEOUT_WIDTH, 8: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high (`ENABLE); forces IDLE on the next edge.
- mem_op  in  4  NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8; others are treated as NONE.
- mem_addr  in  32  effective byte address from EX/MEM.
- mem_store_data  in  32  register value to store (low bits used for SB/SH).
- stall_request  out  1  holds PC/IF/ID/EX/MEM registers while high.
- load_data  out  32  extended load result; valid only when load_valid is high.
- load_valid  out  1  one-cycle pulse in DONE for load ops.
- misalign_exception  out  1  combinational: op valid and address misaligned.
- bus_error  out  1  one-cycle pulse when a timeout aborts the access.
- bus_req  out  1  request; held high until ack or abort.
- bus_we  out  1  1 = write.
- bus_addr  out  32  {mem_addr[31:2], 2'b00}.
- bus_sel  out  4  byte enables; sel[3] = byte at offset 0 (bits 31:24).
- bus_wdata  out  32  store data replicated into lanes.
- bus_ack  in  1  one-cycle completion strobe.
- bus_rdata  in  32  read word; valid when bus_ack is high.

Behaviour:
- Reset outputs: bus_req, bus_we, load_valid, bus_error = 0. bus_addr, bus_sel, bus_wdata, load_data = 0. State = IDLE, counter = 0.
- Misalignment:
  - LH/LHU/SH: misaligned when addr[0] != 0.
  - LW/SW: misaligned when addr[1:0] != 0.
  - A misaligned op issues no bus request and raises no stall; misalign_exception stays high while the op is presented.
- IDLE:
  - On a valid, aligned op, stall_request goes high combinationally in the same cycle.
  - Next edge: latch op, byte offset, bus_addr, bus_sel, bus_wdata; set bus_req=1 and bus_we (store ops only); go to WAIT_ACK.
- WAIT_ACK:
  - stall_request = 1.
  - Counter increments each cycle.
  - On bus_ack: latch extended rdata, drop bus_req, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES without ack: drop bus_req, pulse bus_error, go to DONE. load_data becomes 0.
- DONE:
  - stall_request = 0, so the pipeline advances at the end of this cycle.
  - load_valid = 1 for loads.
  - Next edge returns to IDLE unconditionally. The op visible during DONE is the completed one and is not re-issued.
- Latency:
  - Best case (ack in the first WAIT_ACK cycle) = 3 cycles of occupancy, 2 of them stalled.
  - Loads: ack edge to load_valid = 1 cycle.
- Load extraction by offset (big-endian):
  - Byte at offset o = rdata[31-8o -: 8].
  - Half at offset 0 = rdata[31:16]; half at offset 2 = rdata[15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Store lanes:
  - SB: sel = 4'b1000 >> o; wdata = byte replicated 4x.
  - SH: sel = 1100 (offset 0) or 0011 (offset 2); wdata = half replicated 2x.
  - SW: sel = 1111.
- Edge cases:
  - bus_ack outside WAIT_ACK is ignored.
  - Reset in WAIT_ACK returns to IDLE and deasserts bus_req on that edge; a later ack is ignored.
  - An ack arriving in the same cycle the timeout is reached wins: the access completes normally.

Decomposition:
- Shared `define constants in utility.v: MEM_OP_BUS (3:0), the MEM_OP_* codes, and the FSM state encodings (IDLE/WAIT_ACK/DONE).
- Sub-module mem_lane_align (combinational): given op, offset and store data, produces bus_sel and bus_wdata; given rdata, produces extended load_data.
- The FSM and timeout counter stay in mem_access_ctrl.

Test Plan:
- LW at 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF -> bus_addr 0x100, sel 1111; stall for 3 cycles; load_valid with load_data 0xDEADBEEF.
- LB at 0x203 with rdata 0x000000F0 -> sel 0001; load_data 0xFFFFFFF0. LBU at the same address -> 0x000000F0.
- SH at 0x102, store data 0x00001234 -> bus_we 1, sel 0011, wdata 0x12341234; ack -> DONE, load_valid stays 0.
- LW at 0x101 -> misalign_exception 1, bus_req stays 0, stall_request 0.
- LW with no ack, TIMEOUT_CYCLES=4 -> bus_req high for 4 cycles; bus_error pulses; load_data 0; pipeline released.
- Reset asserted during WAIT_ACK, then a late ack -> bus_req 0 after the reset edge; state IDLE; no load_valid.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// operation codes, FSM states and operand classification helpers.
package mem_access_ctrl_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2
  } state_e;

  function automatic logic op_valid(logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  function automatic logic is_load(logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic logic is_store(logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic logic misaligned(logic [3:0] op, logic [1:0] offset);
    case (op)
      OP_LH, OP_LHU, OP_SH: return offset[0];
      OP_LW, OP_SW:         return |offset;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and bus-side signals of the memory access controller.
// master = controller view, slave = pipeline/memory view.
interface mem_access_ctrl_if;
  import mem_access_ctrl_pkg::*;

  logic [3:0]        mem_op;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_store_data;
  logic              stall_request;
  logic [DATA_W-1:0] load_data;
  logic              load_valid;
  logic              misalign_exception;
  logic              bus_error;
  logic              bus_req;
  logic              bus_we;
  logic [DATA_W-1:0] bus_addr;
  logic [3:0]        bus_sel;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    input  mem_op, mem_addr, mem_store_data, bus_ack, bus_rdata,
    output stall_request, load_data, load_valid, misalign_exception, bus_error,
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata
  );

  modport slave (
    output mem_op, mem_addr, mem_store_data, bus_ack, bus_rdata,
    input  stall_request, load_data, load_valid, misalign_exception, bus_error,
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata
  );

endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational big-endian lane steering: byte enables and replicated write
// data for stores, sub-word extraction and extension for loads.
module mem_access_ctrl_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        sel,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data
);

  function automatic logic [DATA_W-1:0] sext8(logic signed [7:0] v);
    logic signed [DATA_W-1:0] w;
    w = {{(DATA_W-8){v[7]}}, v};
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] sext16(logic signed [15:0] v);
    logic signed [DATA_W-1:0] w;
    w = {{(DATA_W-16){v[15]}}, v};
    return w;
  endfunction

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Offset 0 is the most significant byte of the word.
  always_comb begin
    rbyte = rdata[7:0];
    case (offset)
      2'd0:    rbyte = rdata[31:24];
      2'd1:    rbyte = rdata[23:16];
      2'd2:    rbyte = rdata[15:8];
      default: rbyte = rdata[7:0];
    endcase
    rhalf = offset[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    load_data = '0;
    case (op)
      OP_LB:   load_data = sext8(rbyte);
      OP_LBU:  load_data = {24'd0, rbyte};
      OP_LH:   load_data = sext16(rhalf);
      OP_LHU:  load_data = {16'd0, rhalf};
      OP_LW:   load_data = rdata;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    sel   = 4'b0000;
    wdata = '0;
    case (op)
      OP_LB, OP_LBU, OP_SB: begin
        sel   = 4'b1000 >> offset;
        wdata = {4{store_data[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        sel   = offset[1] ? 4'b0011 : 4'b1100;
        wdata = {2{store_data[15:0]}};
      end
      OP_LW, OP_SW: begin
        sel   = 4'b1111;
        wdata = store_data;
      end
      default: begin
        sel   = 4'b0000;
        wdata = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: issues one req/ack bus access per op,
// stalls the pipeline while it is outstanding and aborts on timeout.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic              clock,
  input  logic              reset,
  mem_access_ctrl_if.master mif
);

  localparam logic [TIMEOUT_WIDTH-1:0] LAST_WAIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                   state, state_next;
  logic [TIMEOUT_WIDTH-1:0] count;
  logic [3:0]               op_r;
  logic [1:0]               off_r;

  logic                     op_ok;
  logic                     mis;
  logic                     issue;
  logic                     timeout_hit;
  logic [3:0]               align_op;
  logic [1:0]               align_off;
  logic [3:0]               align_sel;
  logic [DATA_W-1:0]        align_wdata;
  logic [DATA_W-1:0]        align_load;

  assign op_ok       = op_valid(mif.mem_op);
  assign mis         = misaligned(mif.mem_op, mif.mem_addr[1:0]);
  assign issue       = op_ok && !mis;
  assign timeout_hit = (count == LAST_WAIT);

  assign mif.misalign_exception = op_ok && mis;
  assign mif.stall_request      = ((state == IDLE) && issue) || (state == WAIT_ACK);
  assign mif.load_valid         = (state == DONE) && is_load(op_r);

  // In IDLE the lanes follow the presented op; afterwards the latched op.
  assign align_op  = (state == IDLE) ? mif.mem_op : op_r;
  assign align_off = (state == IDLE) ? mif.mem_addr[1:0] : off_r;

  mem_access_ctrl_lane_align u_align (
    .op         (align_op),
    .offset     (align_off),
    .store_data (mif.mem_store_data),
    .rdata      (mif.bus_rdata),
    .sel        (align_sel),
    .wdata      (align_wdata),
    .load_data  (align_load)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // An ack in the last allowed wait cycle is checked first, so it wins.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (issue) state_next = WAIT_ACK;
      WAIT_ACK: if (mif.bus_ack || timeout_hit) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count         <= '0;
      mif.bus_req   <= 1'b0;
      mif.bus_we    <= 1'b0;
      mif.bus_error <= 1'b0;
      mif.bus_addr  <= '0;
      mif.bus_sel   <= 4'b0000;
      mif.bus_wdata <= '0;
      mif.load_data <= '0;
    end else begin
      mif.bus_error <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            op_r          <= mif.mem_op;
            off_r         <= mif.mem_addr[1:0];
            mif.bus_addr  <= {mif.mem_addr[31:2], 2'b00};
            mif.bus_sel   <= align_sel;
            mif.bus_wdata <= align_wdata;
            mif.bus_req   <= 1'b1;
            mif.bus_we    <= is_store(mif.mem_op);
            count         <= '0;
          end
        end
        WAIT_ACK: begin
          if (mif.bus_ack) begin
            mif.load_data <= align_load;
            mif.bus_req   <= 1'b0;
            mif.bus_we    <= 1'b0;
          end else if (timeout_hit) begin
            mif.load_data <= '0;
            mif.bus_req   <= 1'b0;
            mif.bus_we    <= 1'b0;
            mif.bus_error <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: each transaction is expanded into its expected
// per-cycle output timeline, which a compare process checks every cycle.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int T = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if mif();

  mem_access_ctrl #(.TIMEOUT_CYCLES(T), .TIMEOUT_WIDTH(3)) dut (
    .clock (clk),
    .reset (rst),
    .mif   (mif)
  );

  typedef struct {
    logic        stall, req, we, mis, lv, berr;
    logic [31:0] addr, wdata, ldata;
    logic [3:0]  sel;
    bit          chk_bus, chk_wd, chk_ld;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_size(int op);
    case (op)
      1, 2, 6: return 1;
      3, 4, 7: return 2;
      5, 8:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic m_is_load(int op);
    return (op >= 1) && (op <= 5);
  endfunction

  function automatic logic [3:0] m_sel(int op, int off);
    logic [3:0] s = 4'b0000;
    int n = m_size(op);
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + n) s[3-i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(int op, logic [31:0] d);
    int n = m_size(op);
    logic [31:0] v, w;
    if (n == 0) return 32'h0;
    v = (n == 4) ? d : (d & ((32'h1 << (8*n)) - 32'h1));
    w = 32'h0;
    for (int k = 0; k < 4 / n; k++) w = w | (v << (8*n*k));
    return w;
  endfunction

  function automatic logic [31:0] m_load(int op, int off, logic [31:0] rd);
    int n = m_size(op);
    logic [31:0] v;
    if (n == 1) begin
      v = (rd >> (8*(3-off))) & 32'hFF;
      if (op == 1 && v >= 32'd128) v = v | 32'hFFFFFF00;
      return v;
    end
    if (n == 2) begin
      v = (rd >> (8*(2-off))) & 32'hFFFF;
      if (op == 3 && v >= 32'd32768) v = v | 32'hFFFF0000;
      return v;
    end
    if (op == 5) return rd;
    return 32'h0;
  endfunction

  function automatic exp_t quiet();
    exp_t e;
    e.stall = 0; e.req = 0; e.we = 0; e.mis = 0; e.lv = 0; e.berr = 0;
    e.addr = 0; e.wdata = 0; e.ldata = 0; e.sel = 0;
    e.chk_bus = 0; e.chk_wd = 0; e.chk_ld = 0;
    return e;
  endfunction

  function automatic exp_t zeroed();
    exp_t e = quiet();
    e.chk_bus = 1; e.chk_wd = 1; e.chk_ld = 1;
    return e;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("stall_request", 32'(mif.stall_request), 32'(cur.stall));
      chk("bus_req", 32'(mif.bus_req), 32'(cur.req));
      chk("misalign_exception", 32'(mif.misalign_exception), 32'(cur.mis));
      chk("load_valid", 32'(mif.load_valid), 32'(cur.lv));
      chk("bus_error", 32'(mif.bus_error), 32'(cur.berr));
      if (cur.chk_bus) begin
        chk("bus_we", 32'(mif.bus_we), 32'(cur.we));
        chk("bus_addr", mif.bus_addr, cur.addr);
        chk("bus_sel", 32'(mif.bus_sel), 32'(cur.sel));
      end
      if (cur.chk_wd) chk("bus_wdata", mif.bus_wdata, cur.wdata);
      if (cur.chk_ld) chk("load_data", mif.load_data, cur.ldata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(int op, logic [31:0] a, logic [31:0] d, logic ack, logic [31:0] rd);
    mif.mem_op         = 4'(op);
    mif.mem_addr       = a;
    mif.mem_store_data = d;
    mif.bus_ack        = ack;
    mif.bus_rdata      = rd;
  endtask

  // k = WAIT_ACK cycle (1..T) in which ack arrives; 0 = never (timeout).
  task automatic run_op(int op, logic [31:0] addr, logic [31:0] sd, logic [31:0] rd, int k);
    exp_t e;
    int off = int'(addr[1:0]);
    int n   = m_size(op);
    int waits;
    step();
    set_in(op, addr, sd, 1'($urandom_range(0, 1)), $urandom);
    e = quiet();
    if (n == 0) begin exp_q.push_back(e); return; end
    if (off % n != 0) begin e.mis = 1; exp_q.push_back(e); return; end
    e.stall = 1;
    exp_q.push_back(e);
    waits = (k == 0) ? T : k;
    for (int w = 1; w <= waits; w++) begin
      step();
      set_in(op, addr, sd, w == k, (w == k) ? rd : $urandom);
      e = quiet();
      e.stall = 1; e.req = 1; e.we = (op >= 6);
      e.addr = addr & ~32'h3; e.sel = m_sel(op, off); e.chk_bus = 1;
      if (op >= 6) begin e.chk_wd = 1; e.wdata = m_wdata(op, sd); end
      exp_q.push_back(e);
    end
    step();
    set_in(op, addr, sd, 1'($urandom_range(0, 1)), $urandom);
    e = quiet();
    e.lv     = m_is_load(op);
    e.berr   = (k == 0);
    e.chk_ld = m_is_load(op) || (k == 0);
    e.ldata  = (k == 0) ? 32'h0 : m_load(op, off, rd);
    exp_q.push_back(e);
  endtask

  task automatic reset_in_wait();
    exp_t e;
    step(); set_in(5, 32'h40, 32'h0, 1'b0, 32'h0);
    e = quiet(); e.stall = 1; exp_q.push_back(e);
    for (int w = 1; w <= 2; w++) begin
      step(); set_in(5, 32'h40, 32'h0, 1'b0, 32'h0);
      rst = (w == 2);
      e = quiet(); e.stall = 1; e.req = 1; e.addr = 32'h40; e.sel = 4'b1111; e.chk_bus = 1;
      exp_q.push_back(e);
    end
    step(); rst = 1'b0; set_in(0, 32'h0, 32'h0, 1'b1, 32'hCAFEF00D);
    exp_q.push_back(zeroed());
    step(); set_in(0, 32'h0, 32'h0, 1'b0, 32'h0);
    exp_q.push_back(zeroed());
  endtask

  initial begin
    int op, k;
    logic [31:0] a;
    set_in(0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(zeroed());

    // model pins
    chk("pin_lw", m_load(5, 0, 32'hDEADBEEF), 32'hDEADBEEF);
    chk("pin_lb", m_load(1, 3, 32'h000000F0), 32'hFFFFFFF0);
    chk("pin_lbu", m_load(2, 3, 32'h000000F0), 32'h000000F0);
    chk("pin_lh_off2", m_load(3, 2, 32'h1234ABCD), 32'hFFFFABCD);
    chk("pin_sel_lb3", 32'(m_sel(1, 3)), 32'h1);
    chk("pin_sel_sh2", 32'(m_sel(7, 2)), 32'h3);
    chk("pin_wdata_sh", m_wdata(7, 32'h00001234), 32'h12341234);
    chk("pin_wdata_sb", m_wdata(6, 32'hABCDEF5A), 32'h5A5A5A5A);

    // directed scenarios
    run_op(5, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    run_op(1, 32'h203, 32'h0, 32'h000000F0, 1);
    run_op(2, 32'h203, 32'h0, 32'h000000F0, 1);
    run_op(7, 32'h102, 32'h00001234, 32'h0, 1);
    run_op(5, 32'h101, 32'h0, 32'h0, 1);
    run_op(5, 32'h300, 32'h0, 32'h12345678, 0);
    run_op(4, 32'h302, 32'h0, 32'h8001FFFF, T);
    run_op(8, 32'h304, 32'h0BADCAFE, 32'h0, 0);
    run_op(12, 32'h0, 32'h0, 32'h0, 1);
    reset_in_wait();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 8);
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      k  = $urandom_range(0, T);
      run_op(op, a, $urandom, $urandom, k);
    end

    step();
    set_in(0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    chk("expect_queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
